// File: rtl/mouse_cursor_overlay.sv
// Two-stage pixel pipeline that overlays a 16x16 arrow sprite at the mouse position
// latched once per frame on the rising edge of vsync.
module mouse_cursor_overlay #(
    parameter int          C_bits          = 10,
    parameter logic [23:0] C_color_outline = 24'h000000,
    parameter logic [23:0] C_color_fill    = 24'hFFFFFF,
    parameter logic [23:0] C_color_press   = 24'hFF4000
) (
    input  logic              clk_pixel,
    input  logic              resetn,
    input  logic              cursor_ena,
    input  logic [C_bits-1:0] mouse_x,
    input  logic [C_bits-1:0] mouse_y,
    input  logic [2:0]        mouse_btn,
    input  logic [C_bits-1:0] beam_x,
    input  logic [C_bits-1:0] beam_y,
    input  logic [7:0]        in_red,
    input  logic [7:0]        in_green,
    input  logic [7:0]        in_blue,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              in_blank,
    output logic [7:0]        out_red,
    output logic [7:0]        out_green,
    output logic [7:0]        out_blue,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic              out_blank
);

    logic [C_bits-1:0] cur_x_q, cur_x_d;
    logic [C_bits-1:0] cur_y_q, cur_y_d;
    logic [2:0]        cur_btn_q, cur_btn_d;
    logic              vsync_prev_q, vsync_prev_d;

    logic              s1_hit_q, s1_hit_d;
    logic [3:0]        s1_dx_q, s1_dx_d;
    logic [3:0]        s1_dy_q, s1_dy_d;
    logic [23:0]       s1_rgb_q, s1_rgb_d;
    logic              s1_hsync_q, s1_hsync_d;
    logic              s1_vsync_q, s1_vsync_d;
    logic              s1_blank_q, s1_blank_d;

    logic [23:0]       out_rgb_q, out_rgb_d;
    logic              out_hsync_q, out_hsync_d;
    logic              out_vsync_q, out_vsync_d;
    logic              out_blank_q, out_blank_d;

    logic [C_bits:0]   dx_full;
    logic [C_bits:0]   dy_full;
    logic [1:0]        sprite_code;

    // Frame latch: stage 1 sees the old position during the edge cycle itself.
    always_comb begin
        vsync_prev_d = in_vsync;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        cur_btn_d    = cur_btn_q;
        if (in_vsync && !vsync_prev_q) begin
            cur_x_d   = mouse_x;
            cur_y_d   = mouse_y;
            cur_btn_d = mouse_btn;
        end
    end

    // The extra top bit is the borrow; a set borrow means the beam is left of / above the cursor.
    always_comb begin
        dx_full    = {1'b0, beam_x} - {1'b0, cur_x_q};
        dy_full    = {1'b0, beam_y} - {1'b0, cur_y_q};
        s1_hit_d   = cursor_ena
                     && !dx_full[C_bits] && !dy_full[C_bits]
                     && (dx_full[C_bits-1:4] == '0)
                     && (dy_full[C_bits-1:4] == '0);
        s1_dx_d    = dx_full[3:0];
        s1_dy_d    = dy_full[3:0];
        s1_rgb_d   = {in_red, in_green, in_blue};
        s1_hsync_d = in_hsync;
        s1_vsync_d = in_vsync;
        s1_blank_d = in_blank;
    end

    // Arrow shape: tip at the hotspot, diagonal and left edge outlined, interior filled.
    always_comb begin
        sprite_code = 2'b00;
        if (s1_dy_q == 4'd0 && s1_dx_q == 4'd0) begin
            sprite_code = 2'b11;
        end else if (s1_dy_q >= 4'd1 && s1_dy_q <= 4'd11) begin
            if (s1_dx_q == 4'd0 || s1_dx_q == s1_dy_q) begin
                sprite_code = 2'b01;
            end else if (s1_dx_q < s1_dy_q) begin
                sprite_code = 2'b10;
            end
        end
    end

    always_comb begin
        out_hsync_d = s1_hsync_q;
        out_vsync_d = s1_vsync_q;
        out_blank_d = s1_blank_q;
        out_rgb_d   = s1_rgb_q;
        if (s1_blank_q) begin
            out_rgb_d = 24'h000000;
        end else if (s1_hit_q) begin
            case (sprite_code)
                2'b01:   out_rgb_d = C_color_outline;
                2'b10:   out_rgb_d = (cur_btn_q != 3'b000) ? C_color_press : C_color_fill;
                2'b11:   out_rgb_d = ~s1_rgb_q;
                default: out_rgb_d = s1_rgb_q;
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            cur_btn_q    <= 3'b000;
            vsync_prev_q <= 1'b0;
            s1_hit_q     <= 1'b0;
            s1_dx_q      <= 4'd0;
            s1_dy_q      <= 4'd0;
            s1_rgb_q     <= 24'h000000;
            s1_hsync_q   <= 1'b0;
            s1_vsync_q   <= 1'b0;
            s1_blank_q   <= 1'b1;
            out_rgb_q    <= 24'h000000;
            out_hsync_q  <= 1'b0;
            out_vsync_q  <= 1'b0;
            out_blank_q  <= 1'b1;
        end else begin
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            cur_btn_q    <= cur_btn_d;
            vsync_prev_q <= vsync_prev_d;
            s1_hit_q     <= s1_hit_d;
            s1_dx_q      <= s1_dx_d;
            s1_dy_q      <= s1_dy_d;
            s1_rgb_q     <= s1_rgb_d;
            s1_hsync_q   <= s1_hsync_d;
            s1_vsync_q   <= s1_vsync_d;
            s1_blank_q   <= s1_blank_d;
            out_rgb_q    <= out_rgb_d;
            out_hsync_q  <= out_hsync_d;
            out_vsync_q  <= out_vsync_d;
            out_blank_q  <= out_blank_d;
        end
    end

    assign out_red   = out_rgb_q[23:16];
    assign out_green = out_rgb_q[15:8];
    assign out_blue  = out_rgb_q[7:0];
    assign out_hsync = out_hsync_q;
    assign out_vsync = out_vsync_q;
    assign out_blank = out_blank_q;

endmodule
